// File: rtl/shift_ring_counter.sv
// Johnson / one-hot ring counter with sequence index, legality flag and wrap pulse.
// Optional macro SHIFT_RING_SELF_CORRECT_EN: an enabled step from an illegal pattern reloads the seed.
module shift_ring_counter #(
  parameter  int WIDTH = 4,
  parameter  int MODE  = 0,
  localparam int IDXW  = $clog2(2 * WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic [IDXW-1:0]  idx,
  output logic             illegal,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] SEED = (MODE == 0) ? '0 : WIDTH'(1);

  logic [WIDTH-1:0] q_q, q_d, shift_v;
  logic             wrap_q, wrap_d;
  logic             legal;
  logic [IDXW-1:0]  idx_v;

  always_comb begin : decode
    int trans;
    int ones;
    int pos;
    trans = 0;
    ones  = 0;
    pos   = 0;
    legal = 1'b0;
    idx_v = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (q_q[i]) begin
        ones = ones + 1;
        pos  = i;
      end
    end
    for (int i = 0; i < WIDTH - 1; i++) begin
      if (q_q[i] != q_q[i+1]) trans = trans + 1;
    end
    // A single 0/1 boundary is exactly the set of Johnson patterns
    if (MODE == 0) begin
      legal = (trans <= 1);
      if (q_q == '0)   idx_v = '0;
      else if (q_q[0]) idx_v = IDXW'(ones);
      else             idx_v = IDXW'(2 * WIDTH - ones);
    end else begin
      legal = (ones == 1);
      idx_v = IDXW'(pos);
    end
    if (!legal) idx_v = '0;
  end

  always_comb begin
    shift_v = q_q;
    if (MODE == 0) begin
      shift_v = dir ? {~q_q[0], q_q[WIDTH-1:1]} : {q_q[WIDTH-2:0], ~q_q[WIDTH-1]};
    end else begin
      shift_v = dir ? {q_q[0], q_q[WIDTH-1:1]} : {q_q[WIDTH-2:0], q_q[WIDTH-1]};
    end
  end

  always_comb begin
    q_d    = q_q;
    wrap_d = 1'b0;
    if (load) begin
      q_d = load_val;
    end else if (en) begin
`ifdef SHIFT_RING_SELF_CORRECT_EN
      if (!legal) begin
        q_d = SEED;
      end else begin
        q_d    = shift_v;
        wrap_d = (shift_v == SEED);
      end
`else
      q_d    = shift_v;
      wrap_d = (shift_v == SEED);
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_q    <= SEED;
      wrap_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
    end
  end

  assign q       = q_q;
  assign idx     = idx_v;
  assign illegal = ~legal;
  assign wrap    = wrap_q;

endmodule

// File: tb/tb_shift_ring_counter.sv
// Bench for shift_ring_counter: directed vector table, hand sequences and a randomized
// run against a sequence-position model (Johnson W=4 and ring W=5 instances).
module tb_shift_ring_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       a_en, a_dir, a_load;
  logic [3:0] a_lv, a_q;
  logic [2:0] a_idx;
  logic       a_ill, a_wrap;
  logic       b_en, b_dir, b_load;
  logic [4:0] b_lv, b_q;
  logic [3:0] b_idx;
  logic       b_ill, b_wrap;

  int errors = 0;
  int checks = 0;

  shift_ring_counter #(.WIDTH(4), .MODE(0)) dut_a (
    .clk(clk), .rst(rst), .en(a_en), .dir(a_dir), .load(a_load), .load_val(a_lv),
    .q(a_q), .idx(a_idx), .illegal(a_ill), .wrap(a_wrap));

  shift_ring_counter #(.WIDTH(5), .MODE(1)) dut_b (
    .clk(clk), .rst(rst), .en(b_en), .dir(b_dir), .load(b_load), .load_val(b_lv),
    .q(b_q), .idx(b_idx), .illegal(b_ill), .wrap(b_wrap));

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model: states are listed by sequence position
  function automatic int period(input int w, input int mode);
    return (mode == 0) ? 2 * w : w;
  endfunction

  function automatic int seq_state(input int w, input int mode, input int p);
    int mask;
    mask = (1 << w) - 1;
    if (mode == 1) return 1 << p;
    if (p <= w) return (1 << p) - 1;
    return mask & ~((1 << (p - w)) - 1);
  endfunction

  function automatic int find_idx(input int w, input int mode, input int v);
    for (int p = 0; p < period(w, mode); p++)
      if (seq_state(w, mode, p) == v) return p;
    return -1;
  endfunction

  function automatic int raw_shift(input int w, input int mode, input logic d, input int v);
    int mask;
    int msb;
    int lsb;
    mask = (1 << w) - 1;
    msb  = (v >> (w - 1)) & 1;
    lsb  = v & 1;
    if (mode == 0) begin
      msb = 1 - msb;
      lsb = 1 - lsb;
    end
    if (d) return (v >> 1) | (lsb << (w - 1));
    return ((v << 1) | msb) & mask;
  endfunction

  function automatic void mstep(input int w, input int mode, input logic ld, input logic e,
                                input logic d, input int lv, input int cur,
                                output int nq, output int nw);
    int k;
    int per;
    int seed;
    per  = period(w, mode);
    seed = seq_state(w, mode, 0);
    nq   = cur;
    nw   = 0;
    if (ld) begin
      nq = lv & ((1 << w) - 1);
    end else if (e) begin
      k = find_idx(w, mode, cur);
      if (k < 0) begin
`ifdef SHIFT_RING_SELF_CORRECT_EN
        nq = seed;
`else
        nq = raw_shift(w, mode, d, cur);
        nw = (nq == seed) ? 1 : 0;
`endif
      end else begin
        k  = d ? (k + per - 1) % per : (k + 1) % per;
        nq = seq_state(w, mode, k);
        nw = (k == 0) ? 1 : 0;
      end
    end
  endfunction

  typedef struct {
    logic       ld;
    logic       en;
    logic       dir;
    logic [3:0] lv;
    logic [3:0] q;
    int         idx;
    logic       ill;
    logic       wrap;
  } vec_t;

  vec_t tbl[18];

  task automatic do_reset();
    a_en = 0; a_dir = 0; a_load = 0; a_lv = '0;
    b_en = 0; b_dir = 0; b_load = 0; b_lv = '0;
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int ma, mb, na, nb, wa, wb, ka, kb;
    int exp_b[5];

    tbl[0]  = '{1'b0, 1'b1, 1'b0, 4'h0, 4'b0001, 1, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 4'h0, 4'b0011, 2, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 4'h0, 4'b0111, 3, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 4'h0, 4'b1111, 4, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 4'h0, 4'b1110, 5, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 4'h0, 4'b1100, 6, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 4'h0, 4'b1000, 7, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 4'h0, 4'b0000, 0, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 1'b1, 1'b1, 4'h0, 4'b1000, 7, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 1'b1, 4'h0, 4'b1100, 6, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 1'b1, 4'h0, 4'b1110, 5, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 4'h0, 4'b1100, 6, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 4'h0, 4'b1100, 6, 1'b0, 1'b0};
    tbl[13] = '{1'b1, 1'b1, 1'b0, 4'b0011, 4'b0011, 2, 1'b0, 1'b0};
    tbl[14] = '{1'b0, 1'b1, 1'b1, 4'h0, 4'b0001, 1, 1'b0, 1'b0};
    tbl[15] = '{1'b0, 1'b1, 1'b1, 4'h0, 4'b0000, 0, 1'b0, 1'b1};
    tbl[16] = '{1'b0, 1'b0, 1'b1, 4'h0, 4'b0000, 0, 1'b0, 1'b0};
    tbl[17] = '{1'b1, 1'b0, 1'b0, 4'b0101, 4'b0101, 0, 1'b1, 1'b0};
    exp_b = '{2, 4, 8, 16, 1};

    a_en = 0; a_dir = 0; a_load = 0; a_lv = '0;
    b_en = 0; b_dir = 0; b_load = 0; b_lv = '0;
    rst = 1'b0;
    #12;
    check("reset a_q", int'(a_q), 0);
    check("reset a_idx", int'(a_idx), 0);
    check("reset a_ill", int'(a_ill), 0);
    check("reset a_wrap", int'(a_wrap), 0);
    check("reset b_q", int'(b_q), 1);
    check("reset b_idx", int'(b_idx), 0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 18; i++) begin
      a_load = tbl[i].ld; a_en = tbl[i].en; a_dir = tbl[i].dir; a_lv = tbl[i].lv;
      @(negedge clk);
      check($sformatf("vec%0d q", i), int'(a_q), int'(tbl[i].q));
      check($sformatf("vec%0d idx", i), int'(a_idx), tbl[i].idx);
      check($sformatf("vec%0d illegal", i), int'(a_ill), int'(tbl[i].ill));
      check($sformatf("vec%0d wrap", i), int'(a_wrap), int'(tbl[i].wrap));
    end

    // Enabled forward step from illegal 0101
    a_load = 0; a_en = 1; a_dir = 0;
    @(negedge clk);
`ifdef SHIFT_RING_SELF_CORRECT_EN
    check("illegal step q", int'(a_q), 0);
    check("illegal step illegal", int'(a_ill), 0);
`else
    check("illegal step q", int'(a_q), 4'b1011);
    check("illegal step illegal", int'(a_ill), 1);
`endif
    check("illegal step idx", int'(a_idx), 0);
    check("illegal step wrap", int'(a_wrap), 0);

    // Async reset between edges: right after a wrap, then mid-sequence
    do_reset();
    a_en = 1; a_dir = 0;
    for (int i = 0; i < 7; i++) @(negedge clk);
    @(posedge clk);
    #1;
    check("pre-reset wrap", int'(a_wrap), 1);
    rst = 1'b0;
    #1;
    check("async reset wrap", int'(a_wrap), 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("mid-seq q before reset", int'(a_q), 4'b0011);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("async reset q", int'(a_q), 0);
    check("async reset idx", int'(a_idx), 0);
    @(posedge clk);
    #1;
    check("held in reset q", int'(a_q), 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("first step after reset", int'(a_q), 4'b0001);

    // Ring W=5 forward lap
    do_reset();
    b_en = 1; b_dir = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("ring step%0d q", i), int'(b_q), exp_b[i]);
      check($sformatf("ring step%0d illegal", i), int'(b_ill), 0);
      check($sformatf("ring step%0d wrap", i), int'(b_wrap), (i == 4) ? 1 : 0);
    end

    // Randomized run on both instances
    do_reset();
    ma = 0;
    mb = 1;
    for (int c = 0; c < 400; c++) begin
      a_load = ($urandom_range(7) == 0);
      a_en   = ($urandom_range(3) != 0);
      a_dir  = 1'($urandom_range(1));
      a_lv   = ($urandom_range(1) == 0) ? 4'(seq_state(4, 0, $urandom_range(7))) : 4'($urandom);
      b_load = ($urandom_range(7) == 0);
      b_en   = ($urandom_range(3) != 0);
      b_dir  = 1'($urandom_range(1));
      b_lv   = ($urandom_range(1) == 0) ? 5'(seq_state(5, 1, $urandom_range(4))) : 5'($urandom);
      mstep(4, 0, a_load, a_en, a_dir, int'(a_lv), ma, na, wa);
      mstep(5, 1, b_load, b_en, b_dir, int'(b_lv), mb, nb, wb);
      ma = na;
      mb = nb;
      ka = find_idx(4, 0, ma);
      kb = find_idx(5, 1, mb);
      @(negedge clk);
      check($sformatf("rnd%0d a_q", c), int'(a_q), ma);
      check($sformatf("rnd%0d a_idx", c), int'(a_idx), (ka < 0) ? 0 : ka);
      check($sformatf("rnd%0d a_ill", c), int'(a_ill), (ka < 0) ? 1 : 0);
      check($sformatf("rnd%0d a_wrap", c), int'(a_wrap), wa);
      check($sformatf("rnd%0d b_q", c), int'(b_q), mb);
      check($sformatf("rnd%0d b_idx", c), int'(b_idx), (kb < 0) ? 0 : kb);
      check($sformatf("rnd%0d b_ill", c), int'(b_ill), (kb < 0) ? 1 : 0);
      check($sformatf("rnd%0d b_wrap", c), int'(b_wrap), wb);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
